grid_move_resolver: RTL and testbench

Parametrised successor to the game's move/collision logic. It owns a writable bank of tile maps, holds the player position internally, accepts move requests over a valid/ready handshake and returns the resolved position a fixed two cycles later. Walls and out-of-bounds targets block the move. It sits between the input decoder and the renderer/game-state logic.

---
 rtl/grid_pkg.sv | 19 +
 rtl/tile_map_ram.sv | 59 +++++
 rtl/grid_move_resolver.sv | 203 ++++++++++++++++++++
 tb/tb_grid_move_resolver.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared move encodings, FSM states and default geometry for the grid move resolver.
package grid_pkg;

  localparam int DEF_COLS     = 20;
  localparam int DEF_ROWS     = 15;
  localparam int DEF_NUM_MAPS = 4;

  localparam logic [2:0] MOVE_RIGHT = 3'b100;
  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_LEFT  = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/tile_map_ram.sv
// Bank of tile maps: whole-row writes, single-bit registered reads (read-before-write).
module tile_map_ram #(
  parameter int COLS     = 20,
  parameter int ROWS     = 15,
  parameter int NUM_MAPS = 4,
  parameter int XW       = 5,
  parameter int YW       = 4,
  parameter int MW       = 2
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [MW-1:0]   wr_map,
  input  logic [YW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            rd_en,
  input  logic [MW-1:0]   rd_map,
  input  logic [YW-1:0]   rd_row,
  input  logic [XW-1:0]   rd_col,
  output logic            rd_bit
);

  localparam int DEPTH = NUM_MAPS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COLS-1:0] mem [DEPTH];
  logic [COLS-1:0] wr_bits;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            wr_in_range;
  logic            rd_bit_reg;

  // Stored rows are kept with bit x = column x so reads index by column directly.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign wr_bits[gi] = wr_data[COLS-1-gi];
    end
  endgenerate

  assign wr_addr     = AW'(wr_map) * AW'(ROWS) + AW'(wr_row);
  assign rd_addr     = AW'(rd_map) * AW'(ROWS) + AW'(rd_row);
  // A row index past the map height would alias into the next map, so drop it.
  assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_map) < NUM_MAPS);

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_bit_reg <= mem[rd_addr][rd_col];
    end
  end

  assign rd_bit = rd_bit_reg;

endmodule

// File: rtl/grid_move_resolver.sv
// Resolves player move requests against a writable bank of tile maps; result two cycles after accept.
module grid_move_resolver
  import grid_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int NUM_MAPS = DEF_NUM_MAPS,
  parameter int XW       = $clog2(COLS),
  parameter int YW       = $clog2(ROWS),
  parameter int MW       = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wr_en,
  input  logic [MW-1:0]   wr_map,
  input  logic [YW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            spawn_valid,
  input  logic [XW-1:0]   spawn_x,
  input  logic [YW-1:0]   spawn_y,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_move,
  input  logic [MW-1:0]   req_map,
  output logic            resp_valid,
  output logic            resp_blocked,
  output logic [XW-1:0]   pos_x,
  output logic [YW-1:0]   pos_y,
  output logic [CNTW-1:0] move_count,
  output logic [CNTW-1:0] block_count
);

  state_t          state_reg, state_next;
  logic [XW-1:0]   pos_x_reg, pos_y_dummy_unused_x;
  logic [YW-1:0]   pos_y_reg;
  logic [XW-1:0]   tgt_x_reg, tgt_x_next;
  logic [YW-1:0]   tgt_y_reg, tgt_y_next;
  logic [MW-1:0]   map_reg;
  logic            oob_reg, oob_next;
  logic            real_reg, real_next;
  logic            resp_valid_reg;
  logic            resp_blocked_reg;
  logic [CNTW-1:0] move_count_reg;
  logic [CNTW-1:0] block_count_reg;
  logic            accept;
  logic            rd_en;
  logic            tile_bit;
  logic            blocked;
  logic            do_respond;
  logic            move_inc;
  logic            block_inc;

  assign pos_y_dummy_unused_x = '0;

  tile_map_ram #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .NUM_MAPS (NUM_MAPS),
    .XW       (XW),
    .YW       (YW),
    .MW       (MW)
  ) u_tile_map_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_map  (wr_map),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_map  (map_reg),
    .rd_row  (tgt_y_reg),
    .rd_col  (tgt_x_reg),
    .rd_bit  (tile_bit)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state; a spawn aborts whatever is in flight
  always_comb begin
    state_next = state_reg;
    if (spawn_valid) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (accept) state_next = ST_LOOKUP;
        ST_LOOKUP:  state_next = ST_RESPOND;
        ST_RESPOND: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    req_ready = 1'b0;
    rd_en     = 1'b0;
    case (state_reg)
      ST_IDLE:   req_ready = !wr_en && !spawn_valid;
      ST_LOOKUP: rd_en = 1'b1;
      default:   ;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Target tile; an out-of-range step keeps the current tile so the lookup address stays legal.
  always_comb begin
    tgt_x_next = pos_x_reg;
    tgt_y_next = pos_y_reg;
    oob_next   = 1'b0;
    real_next  = 1'b1;
    case (req_move)
      MOVE_RIGHT: begin
        if (pos_x_reg == XW'(COLS - 1)) oob_next = 1'b1;
        else tgt_x_next = pos_x_reg + 1'b1;
      end
      MOVE_LEFT: begin
        if (pos_x_reg == '0) oob_next = 1'b1;
        else tgt_x_next = pos_x_reg - 1'b1;
      end
      MOVE_UP: begin
        if (pos_y_reg == '0) oob_next = 1'b1;
        else tgt_y_next = pos_y_reg - 1'b1;
      end
      MOVE_DOWN: begin
        if (pos_y_reg == YW'(ROWS - 1)) oob_next = 1'b1;
        else tgt_y_next = pos_y_reg + 1'b1;
      end
      default: real_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tgt_x_reg <= '0;
      tgt_y_reg <= '0;
      map_reg   <= '0;
      oob_reg   <= 1'b0;
      real_reg  <= 1'b0;
    end else if (accept) begin
      tgt_x_reg <= tgt_x_next;
      tgt_y_reg <= tgt_y_next;
      map_reg   <= req_map;
      oob_reg   <= oob_next;
      real_reg  <= real_next;
    end
  end

  // A stay move never consults the tile, so standing on a wall is never a block.
  assign blocked    = oob_reg | (tile_bit & real_reg);
  assign do_respond = (state_reg == ST_RESPOND) && !spawn_valid;
  assign move_inc   = do_respond && !blocked && real_reg;
  assign block_inc  = do_respond && blocked;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x_reg        <= '0;
      pos_y_reg        <= '0;
      resp_valid_reg   <= 1'b0;
      resp_blocked_reg <= 1'b0;
    end else begin
      resp_valid_reg   <= do_respond;
      resp_blocked_reg <= do_respond && blocked;
      if (spawn_valid) begin
        pos_x_reg <= spawn_x;
        pos_y_reg <= spawn_y;
      end else if (do_respond && !blocked) begin
        pos_x_reg <= tgt_x_reg;
        pos_y_reg <= tgt_y_reg;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      move_count_reg  <= '0;
      block_count_reg <= '0;
    end else begin
      if (move_inc && (move_count_reg != '1)) begin
        move_count_reg <= move_count_reg + 1'b1;
      end
      if (block_inc && (block_count_reg != '1)) begin
        block_count_reg <= block_count_reg + 1'b1;
      end
    end
  end

  assign resp_valid   = resp_valid_reg;
  assign resp_blocked = resp_blocked_reg;
  assign pos_x        = pos_x_reg | pos_y_dummy_unused_x;
  assign pos_y        = pos_y_reg;
  assign move_count   = move_count_reg;
  assign block_count  = block_count_reg;

endmodule

// File: tb/tb_grid_move_resolver.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_grid_move_resolver;
  import grid_pkg::*;

  localparam int COLS     = 20;
  localparam int ROWS     = 15;
  localparam int NUM_MAPS = 4;
  localparam int XW       = 5;
  localparam int YW       = 4;
  localparam int MW       = 2;
  localparam int CNTW     = 4;
  localparam int SAT      = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wr_en = 1'b0;
  logic [MW-1:0]   wr_map = '0;
  logic [YW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            spawn_valid = 1'b0;
  logic [XW-1:0]   spawn_x = '0;
  logic [YW-1:0]   spawn_y = '0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_move = '0;
  logic [MW-1:0]   req_map = '0;
  logic            resp_valid;
  logic            resp_blocked;
  logic [XW-1:0]   pos_x;
  logic [YW-1:0]   pos_y;
  logic [CNTW-1:0] move_count;
  logic [CNTW-1:0] block_count;

  grid_move_resolver #(
    .COLS(COLS), .ROWS(ROWS), .NUM_MAPS(NUM_MAPS),
    .XW(XW), .YW(YW), .MW(MW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_map(wr_map), .wr_row(wr_row), .wr_data(wr_data),
    .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .req_valid(req_valid), .req_ready(req_ready), .req_move(req_move), .req_map(req_map),
    .resp_valid(resp_valid), .resp_blocked(resp_blocked),
    .pos_x(pos_x), .pos_y(pos_y),
    .move_count(move_count), .block_count(block_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Reference model: map image (MSB = column 0), position, counters, request pipeline stage
  logic [COLS-1:0] m_map [NUM_MAPS][ROWS];
  int m_x, m_y, m_mc, m_bc, m_stage;
  bit m_valid, m_blocked;
  int p_tx, p_ty, p_map;
  bit p_oob, p_real, p_tile;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_mc = 0; m_bc = 0; m_stage = 0;
    m_valid = 1'b0; m_blocked = 1'b0;
  endtask

  task automatic model_edge();
    bit blk;
    int dx, dy, nx, ny;
    m_valid = 1'b0;
    if (spawn_valid) begin
      m_x = int'(spawn_x); m_y = int'(spawn_y); m_stage = 0;
    end else if (m_stage == 1) begin
      p_tile = p_real && !p_oob && m_map[p_map][p_ty][COLS-1-p_tx];
      m_stage = 2;
    end else if (m_stage == 2) begin
      blk = p_oob || p_tile;
      m_valid = 1'b1;
      m_blocked = blk;
      if (!blk) begin m_x = p_tx; m_y = p_ty; end
      if (blk) m_bc = (m_bc < SAT) ? m_bc + 1 : SAT;
      else if (p_real) m_mc = (m_mc < SAT) ? m_mc + 1 : SAT;
      m_stage = 0;
    end else if (req_valid && !wr_en) begin
      dx = 0; dy = 0;
      case (req_move)
        3'b100: dx = 1;
        3'b010: dx = -1;
        3'b001: dy = -1;
        3'b011: dy = 1;
        default: ;
      endcase
      nx = m_x + dx; ny = m_y + dy;
      p_real = (dx != 0) || (dy != 0);
      p_oob = (nx < 0) || (nx >= COLS) || (ny < 0) || (ny >= ROWS);
      p_tx = p_oob ? m_x : nx;
      p_ty = p_oob ? m_y : ny;
      p_map = int'(req_map);
      m_stage = 1;
    end
    if (wr_en) m_map[wr_map][wr_row] = wr_data;
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0; spawn_valid = 1'b0; req_valid = 1'b0;
  endtask

  task automatic write_row(input int mp, input int r, input logic [COLS-1:0] d);
    wr_en = 1'b1; wr_map = MW'(mp); wr_row = YW'(r); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic spawn(input int x, input int y);
    spawn_valid = 1'b1; spawn_x = XW'(x); spawn_y = YW'(y);
    step();
    spawn_valid = 1'b0;
  endtask

  // Leaves time in the cycle where the response must be visible.
  task automatic do_move(input logic [2:0] mv, input int mp, input string tag);
    req_valid = 1'b1; req_move = mv; req_map = MW'(mp);
    step();
    req_valid = 1'b0;
    step();
    step();
    $display("move %s: dir=%b map=%0d -> valid=%0d blocked=%0d pos=(%0d,%0d) moves=%0d blocks=%0d",
             tag, mv, mp, resp_valid, resp_blocked, pos_x, pos_y, move_count, block_count);
  endtask

  function automatic logic [COLS-1:0] bordered_row(input int r);
    logic [COLS-1:0] v;
    v = (r == 0 || r == ROWS - 1) ? '1 : 20'h80001;
    return v;
  endfunction

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("req_ready", int'(req_ready), int'(m_stage == 0 && !wr_en && !spawn_valid));
        check("resp_valid", int'(resp_valid), int'(m_valid));
        if (m_valid) check("resp_blocked", int'(resp_blocked), int'(m_blocked));
        check("pos_x", int'(pos_x), m_x);
        check("pos_y", int'(pos_y), m_y);
        check("move_count", int'(move_count), m_mc);
        check("block_count", int'(block_count), m_bc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int m = 0; m < NUM_MAPS; m++)
      for (int r = 0; r < ROWS; r++) m_map[m][r] = '0;
    cmp_on = 1'b1;
    step();
    step();
    check("reset pos_x", int'(pos_x), 0);
    check("reset pos_y", int'(pos_y), 0);
    check("reset move_count", int'(move_count), 0);
    check("reset resp_valid", int'(resp_valid), 0);
    check("reset req_ready", int'(req_ready), 1);
    resetn = 1'b1;

    for (int m = 0; m < NUM_MAPS; m++)
      for (int r = 0; r < ROWS; r++)
        write_row(m, r, (m == 1) ? '0 : bordered_row(r));
    write_row(2, 3, 20'h7FFFF);

    spawn(1, 1);
    do_move(MOVE_RIGHT, 0, "right_open");
    check("right valid", int'(resp_valid), 1);
    check("right blocked", int'(resp_blocked), 0);
    check("right pos_x", int'(pos_x), 2);
    check("right pos_y", int'(pos_y), 1);
    check("right move_count", int'(move_count), 1);

    spawn(1, 1);
    do_move(MOVE_UP, 0, "up_wall");
    check("wall blocked", int'(resp_blocked), 1);
    check("wall pos_y", int'(pos_y), 1);
    check("wall block_count", int'(block_count), 1);

    spawn(0, 0);
    do_move(MOVE_LEFT, 1, "left_oob");
    check("oob left blocked", int'(resp_blocked), 1);
    check("oob left pos_x", int'(pos_x), 0);
    do_move(MOVE_UP, 1, "up_oob");
    check("oob up blocked", int'(resp_blocked), 1);
    check("oob up pos_y", int'(pos_y), 0);
    check("oob block_count", int'(block_count), 3);

    spawn(5, 2);
    do_move(MOVE_DOWN, 2, "down_map2");
    check("map2 blocked", int'(resp_blocked), 1);
    check("map2 pos_y", int'(pos_y), 2);
    do_move(MOVE_DOWN, 0, "down_map0");
    check("map0 blocked", int'(resp_blocked), 0);
    check("map0 pos_x", int'(pos_x), 5);
    check("map0 pos_y", int'(pos_y), 3);

    spawn(0, 0);
    do_move(3'b000, 0, "stay_on_wall");
    check("stay valid", int'(resp_valid), 1);
    check("stay blocked", int'(resp_blocked), 0);
    check("stay move_count", int'(move_count), 2);
    check("stay block_count", int'(block_count), 4);

    spawn(3, 3);
    req_valid = 1'b1; req_move = MOVE_RIGHT; req_map = 2'd0;
    step();
    req_valid = 1'b0;
    spawn_valid = 1'b1; spawn_x = 5'd8; spawn_y = 4'd8;
    step();
    spawn_valid = 1'b0;
    #1;
    check("abort req_ready", int'(req_ready), 1);
    check("abort pos_x", int'(pos_x), 8);
    check("abort pos_y", int'(pos_y), 8);
    step();
    step();
    check("abort resp_valid", int'(resp_valid), 0);
    check("abort move_count", int'(move_count), 2);
    $display("abort: spawn during lookup -> pos=(%0d,%0d) valid=%0d", pos_x, pos_y, resp_valid);

    spawn(1, 1);
    req_valid = 1'b1; req_move = MOVE_RIGHT; req_map = 2'd1;
    step();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_map = 2'd1; wr_row = 4'd1; wr_data = '1;
    step();
    wr_en = 1'b0;
    step();
    check("rbw blocked", int'(resp_blocked), 0);
    check("rbw pos_x", int'(pos_x), 2);
    $display("rbw: write during lookup -> valid=%0d blocked=%0d pos=(%0d,%0d)", resp_valid, resp_blocked, pos_x, pos_y);
    do_move(MOVE_LEFT, 1, "after_write");
    check("new wall blocked", int'(resp_blocked), 1);
    check("new wall pos_x", int'(pos_x), 2);
    write_row(1, 1, '0);

    spawn(1, 1);
    req_valid = 1'b1; req_move = MOVE_RIGHT; req_map = 2'd1;
    step();
    req_valid = 1'b0;
    step();
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst resp_valid", int'(resp_valid), 0);
    check("rst pos_x", int'(pos_x), 0);
    check("rst pos_y", int'(pos_y), 0);
    check("rst move_count", int'(move_count), 0);
    check("rst block_count", int'(block_count), 0);
    step();
    check("rst no resp", int'(resp_valid), 0);
    resetn = 1'b1;
    $display("reset during respond: pos=(%0d,%0d) counters=%0d/%0d", pos_x, pos_y, move_count, block_count);
    step();

    spawn(1, 1);
    for (int i = 0; i < SAT + 1; i++)
      do_move((i % 2 == 0) ? MOVE_RIGHT : MOVE_LEFT, 1, "saturate");
    check("sat move_count", int'(move_count), SAT);

    for (int c = 0; c < 4000; c++) begin
      clear_inputs();
      if ($urandom_range(199) == 0) begin
        resetn = 1'b0;
        model_reset();
        step();
        resetn = 1'b1;
      end else begin
        wr_en = ($urandom_range(9) == 0);
        wr_map = MW'($urandom_range(NUM_MAPS - 1));
        wr_row = YW'($urandom_range(ROWS - 1));
        wr_data = COLS'($urandom & $urandom);
        spawn_valid = ($urandom_range(24) == 0);
        spawn_x = XW'($urandom_range(COLS - 1));
        spawn_y = YW'($urandom_range(ROWS - 1));
        req_valid = ($urandom_range(9) < 7);
        req_move = 3'($urandom_range(7));
        req_map = MW'($urandom_range(NUM_MAPS - 1));
        step();
      end
    end
    clear_inputs();
    step();
    step();
    step();
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
